// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: two half-adder cells plus a carry flop, LSB-first.
// Optional carry-in port enabled by defining SERIAL_ADD_CIN_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, r_q, r_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept, lastBit;
  logic             s1, c1, s, c2, cinLoad;
  logic [WIDTH:0]   rShift;

`ifdef SERIAL_ADD_CIN_EN
  assign cinLoad = cin;
`else
  assign cinLoad = 1'b0;
`endif

  assign accept  = start && (state_q != RUN);
  assign lastBit = (cnt_q == CW'(WIDTH - 1));

  assign s1 = sa_q[0] ^ sb_q[0];
  assign c1 = sa_q[0] & sb_q[0];
  assign s  = s1 ^ c_q;
  assign c2 = s1 & c_q;
  // Wide shift keeps the WIDTH=1 case free of reversed part-selects.
  assign rShift = {s, r_q} >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
  end

  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    r_d    = r_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (accept) begin
      sa_d  = a;
      sb_d  = b;
      c_d   = cinLoad;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      r_d   = rShift[WIDTH-1:0];
      c_d   = c1 | c2;
      cnt_d = cnt_q + CW'(1);
      if (lastBit) begin
        sum_d  = rShift[WIDTH-1:0];
        cout_d = c1 | c2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q   <= '0;
      sb_q   <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      r_q    <= r_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 against a plain a+b(+cin) model.
// Define SERIAL_ADD_CIN_EN to exercise the carry-in build.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         cin1 = 1'b0;
  logic         busy1, done1, cout1;
  logic [0:0]   sum1;

  int compareCount = 0;
  int failCount = 0;
  logic [W:0] lastResult = '0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADD_CIN_EN
    .cin(cin),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADD_CIN_EN
    .cin(cin1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Reference model: the adder result is simply the arithmetic sum.
  function automatic logic [W:0] refSum(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic cEff;
`ifdef SERIAL_ADD_CIN_EN
    cEff = cv;
`else
    cEff = 1'b0;
`endif
    return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cEff};
  endfunction

  task automatic checkOutput(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
  endtask

  // Full operation with hold and handshake checks on every cycle.
  task automatic runOp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0] exp;
    exp = refSum(av, bv, cv);
    applyStimulus(av, bv, cv);
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    checkOutput({tag, "_accept_busy"}, 33'(busy), 33'd1);
    checkOutput({tag, "_accept_done"}, 33'(done), 33'd0);
    for (int i = 1; i < W; i++) begin
      step();
      checkOutput({tag, "_run_busy"}, 33'(busy), 33'd1);
      checkOutput({tag, "_run_done"}, 33'(done), 33'd0);
      checkOutput({tag, "_run_hold"}, 33'({cout, sum}), 33'(lastResult));
    end
    step();
    checkOutput({tag, "_done"}, 33'(done), 33'd1);
    checkOutput({tag, "_done_busy"}, 33'(busy), 33'd0);
    checkOutput({tag, "_result"}, 33'({cout, sum}), 33'(exp));
    lastResult = exp;
    step();
    checkOutput({tag, "_after_done"}, 33'(done), 33'd0);
    checkOutput({tag, "_after_busy"}, 33'(busy), 33'd0);
    checkOutput({tag, "_after_hold"}, 33'({cout, sum}), 33'(exp));
  endtask

  task automatic runOp1(input string tag, input logic av, input logic bv, input logic cv);
    logic [1:0] exp;
    logic cEff;
`ifdef SERIAL_ADD_CIN_EN
    cEff = cv;
`else
    cEff = 1'b0;
`endif
    exp = 2'(av) + 2'(bv) + 2'(cEff);
    start1 = 1'b1;
    a1 = av;
    b1 = bv;
    cin1 = cv;
    step();
    start1 = 1'b0;
    checkOutput({tag, "_w1_busy"}, 33'(busy1), 33'd1);
    checkOutput({tag, "_w1_nodone"}, 33'(done1), 33'd0);
    step();
    checkOutput({tag, "_w1_done"}, 33'(done1), 33'd1);
    checkOutput({tag, "_w1_idlebusy"}, 33'(busy1), 33'd0);
    checkOutput({tag, "_w1_result"}, 33'({cout1, sum1}), 33'(exp));
    step();
    checkOutput({tag, "_w1_after"}, 33'(done1), 33'd0);
  endtask

  initial begin
    logic [W:0] exp;

    #12;
    checkOutput("reset_busy", 33'(busy), 33'd0);
    checkOutput("reset_done", 33'(done), 33'd0);
    checkOutput("reset_result", 33'({cout, sum}), 33'd0);
    rst_n = 1'b1;
    step();

    runOp("t5a33", 8'h5A, 8'h33, 1'b0);
    runOp("tff01", 8'hFF, 8'h01, 1'b0);

    // start re-asserted mid-run must be ignored.
    exp = refSum(8'h5A, 8'h33, 1'b0);
    applyStimulus(8'h5A, 8'h33, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    applyStimulus(8'h01, 8'h01, 1'b0);
    step();
    start = 1'b0;
    checkOutput("ign_busy", 33'(busy), 33'd1);
    for (int i = 4; i < W; i++) step();
    checkOutput("ign_notyet", 33'(done), 33'd0);
    step();
    checkOutput("ign_done", 33'(done), 33'd1);
    checkOutput("ign_result", 33'({cout, sum}), 33'(exp));
    lastResult = exp;
    step();
    checkOutput("ign_after_done", 33'(done), 33'd0);
    step();
    checkOutput("ign_no_extra_done", 33'(done), 33'd0);
    checkOutput("ign_no_extra_busy", 33'(busy), 33'd0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(8'h5A, 8'h33, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 33'(busy), 33'd0);
    checkOutput("rst_done", 33'(done), 33'd0);
    checkOutput("rst_result", 33'({cout, sum}), 33'd0);
    lastResult = '0;
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("rst_stay_idle", 33'(busy), 33'd0);
    runOp("t1020", 8'h10, 8'h20, 1'b0);

    // Back-to-back with start held high.
    applyStimulus(8'h01, 8'h02, 1'b0);
    step();
    a = 8'h80;
    b = 8'h80;
    for (int i = 1; i < W; i++) step();
    checkOutput("b2b_busy1", 33'(busy), 33'd1);
    step();
    checkOutput("b2b_done1", 33'(done), 33'd1);
    checkOutput("b2b_result1", 33'({cout, sum}), 33'(refSum(8'h01, 8'h02, 1'b0)));
    step();
    checkOutput("b2b_reaccept_busy", 33'(busy), 33'd1);
    checkOutput("b2b_reaccept_done", 33'(done), 33'd0);
    checkOutput("b2b_hold", 33'({cout, sum}), 33'(refSum(8'h01, 8'h02, 1'b0)));
    for (int i = 1; i < W; i++) step();
    checkOutput("b2b_notyet", 33'(done), 33'd0);
    step();
    start = 1'b0;
    checkOutput("b2b_done2", 33'(done), 33'd1);
    checkOutput("b2b_result2", 33'({cout, sum}), 33'(refSum(8'h80, 8'h80, 1'b0)));
    lastResult = refSum(8'h80, 8'h80, 1'b0);
    step();
    checkOutput("b2b_after", 33'(done), 33'd0);
    checkOutput("b2b_idle", 33'(busy), 33'd0);

`ifdef SERIAL_ADD_CIN_EN
    runOp("cin_ff00", 8'hFF, 8'h00, 1'b1);
    runOp("cin_1234", 8'h12, 8'h34, 1'b1);
`endif

    for (int k = 0; k < 16; k++) begin
      runOp("rand", W'($urandom), W'($urandom), 1'($urandom));
    end

    runOp1("w1_11", 1'b1, 1'b1, 1'b0);
    runOp1("w1_10", 1'b1, 1'b0, 1'b0);
    runOp1("w1_00c", 1'b0, 1'b0, 1'b1);
    runOp1("w1_11c", 1'b1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
